// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and strobe sequencer for the external async SRAM
// Optional macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties (default round-robin).
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [18:0] r0_adr,
    input  logic [15:0] r0_wdat,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [18:0] r1_adr,
    input  logic [15:0] r1_wdat,
    output logic        r0_ack,
    output logic        r1_ack,
    output logic [15:0] rdat,
    output logic        busy,
    output logic [18:0] ADR,
    output logic [15:0] dat_out,
    output logic        dat_oe,
    input  logic [15:0] dat_in,
    output logic        RAMCS,
    output logic        RAMOE,
    output logic        RAMWE
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_END} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        gnt1_q, gnt1_d;
    logic        last_grant_q, last_grant_d;
    logic [18:0] adr_q, adr_d;
    logic [15:0] dat_out_q, dat_out_d;
    logic        dat_oe_q, dat_oe_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        wen_q, wen_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] rdat_q, rdat_d;
    logic        pick1;
    logic        sel_we;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        gnt1_d       = gnt1_q;
        last_grant_d = last_grant_q;
        adr_d        = adr_q;
        dat_out_d    = dat_out_q;
        dat_oe_d     = dat_oe_q;
        cs_d         = cs_q;
        oe_d         = oe_q;
        wen_d        = wen_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdat_d       = rdat_q;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        pick1        = r1_req && !r0_req;
`else
        // On a tie, the port that did not win last time is served.
        pick1        = r1_req && (!r0_req || !last_grant_q);
`endif
        sel_we       = pick1 ? r1_we : r0_we;

        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    gnt1_d       = pick1;
                    last_grant_d = pick1;
                    we_d         = sel_we;
                    adr_d        = pick1 ? r1_adr : r0_adr;
                    if (sel_we) begin
                        dat_out_d = pick1 ? r1_wdat : r0_wdat;
                    end
                    cnt_d    = CNT_LOAD;
                    cs_d     = 1'b0;
                    oe_d     = sel_we;
                    wen_d    = !sel_we;
                    dat_oe_d = sel_we;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdat_d = dat_in;
                    end
                    // Strobes rise here; ADR and write data stay for one hold cycle.
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    ack0_d  = !gnt1_q;
                    ack1_d  = gnt1_q;
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_END: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            gnt1_q       <= 1'b0;
            last_grant_q <= 1'b1;
            adr_q        <= 19'd0;
            dat_out_q    <= 16'd0;
            dat_oe_q     <= 1'b0;
            cs_q         <= 1'b1;
            oe_q         <= 1'b1;
            wen_q        <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdat_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            gnt1_q       <= gnt1_d;
            last_grant_q <= last_grant_d;
            adr_q        <= adr_d;
            dat_out_q    <= dat_out_d;
            dat_oe_q     <= dat_oe_d;
            cs_q         <= cs_d;
            oe_q         <= oe_d;
            wen_q        <= wen_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdat_q       <= rdat_d;
        end
    end

    assign r0_ack  = ack0_q;
    assign r1_ack  = ack1_q;
    assign rdat    = rdat_q;
    assign busy    = (state_q != S_IDLE);
    assign ADR     = adr_q;
    assign dat_out = dat_out_q;
    assign dat_oe  = dat_oe_q;
    assign RAMCS   = cs_q;
    assign RAMOE   = oe_q;
    assign RAMWE   = wen_q;
endmodule
